// File: rtl/hs4_pkg.sv
// Shared definitions for the hs4 four-phase transmitter: one-hot FSM encoding and
// the FIFO pointer-width helper.
package hs4_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        ASSERT   = 3'b010,
        DEASSERT = 3'b100
    } hs4_state_e;

    // Pointer carries one extra wrap bit above the address bits.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs4_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset to 0.
module hs4_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_tx_fifo.sv
// Buffered four-phase req/ack transmitter: DEPTH-entry register FIFO feeding a one-hot
// handshake FSM. Defining HS4_TX_TIMEOUT_EN adds a sticky watchdog on stalled handshakes.
module hs4_tx_fifo
    import hs4_pkg::*;
#(
    parameter int unsigned DW             = 32,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    input  logic [DW-1:0]               in_data_i,
    output logic                        in_ready_o,
    output logic [ptr_width(DEPTH)-1:0] count_o,
    output logic                        idle_o,
    input  logic                        ack_i,
    output logic                        req_o,
    output logic [DW-1:0]               req_data_o
`ifdef HS4_TX_TIMEOUT_EN
    ,
    input  logic                        tmo_clr_i,
    output logic                        timeout_o
`endif
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;

    if (DW < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $fatal(1, "hs4_tx_fifo: illegal parameter combination");
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic          avail_q, idle_q, req_q;
    logic [DW-1:0] req_data_q;
    hs4_state_e    state_q, state_d;
    logic          ack_s, full, empty, push, pop;

    hs4_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d_i(ack_i),
        .q_o(ack_s)
    );

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = in_valid_i && !full;
    // Launch decision uses a registered availability flag, keeping it off the push path.
    assign pop   = (state_q == IDLE) && avail_q && !empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (pop)    state_d = ASSERT;
            ASSERT:   if (ack_s)  state_d = DEASSERT;
            DEASSERT: if (!ack_s) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            avail_q  <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            avail_q <= !empty;
            idle_q  <= (count_d == '0) && (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            req_data_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        req_q      <= 1'b1;
                        req_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                    end
                end
                ASSERT:   if (ack_s) req_q <= 1'b0;
                DEASSERT: req_q <= 1'b0;
                default:  req_q <= 1'b0;
            endcase
        end
    end

    assign in_ready_o = !full;
    assign count_o    = count_q;
    assign idle_o     = idle_q;
    assign req_o      = req_q;
    assign req_data_o = req_data_q;

`ifdef HS4_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q, waiting, expire;

    assign waiting = (state_q == ASSERT) || (state_q == DEASSERT);
    // Saturating counter fires exactly once per wait state.
    assign expire  = waiting && (state_d == state_q) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (!waiting || state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (expire) begin
                tmo_q <= 1'b1;
            end else if (tmo_clr_i) begin
                tmo_q <= 1'b0;
            end
        end
    end

    assign timeout_o = tmo_q;
`endif

endmodule

// File: tb/tb_hs4_tx_fifo.sv
// Bench for hs4_tx_fifo: scoreboard of pushed words checked at each req_o launch, plus a
// reactive four-phase receiver that checks ack-to-req spacing.
`timescale 1ns/1ps
module tb_hs4_tx_fifo;

    localparam int unsigned DW   = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC = 3;
    localparam int unsigned TMO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o;
    logic [2:0]    count_o;
    logic          idle_o;
    logic          ack_i = 1'b0;
    logic          req_o;
    logic [DW-1:0] req_data_o;
`ifdef HS4_TX_TIMEOUT_EN
    logic          tmo_clr_i = 1'b0;
    logic          timeout_o;
`endif

    hs4_tx_fifo #(
        .DW(DW),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid_i(in_valid_i),
        .in_data_i(in_data_i),
        .in_ready_o(in_ready_o),
        .count_o(count_o),
        .idle_o(idle_o),
        .ack_i(ack_i),
        .req_o(req_o),
        .req_data_o(req_data_o)
`ifdef HS4_TX_TIMEOUT_EN
        ,
        .tmo_clr_i(tmo_clr_i),
        .timeout_o(timeout_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    logic [DW-1:0] exp_q[$];
    int            last_push_edge = 0;

    // Receiver model: acks rx_delay negedges after seeing req, drops ack when req falls.
    int rx_delay = 3;
    bit rx_hold = 1'b0;
    int rx_st = 0;
    int rx_cnt = 0;
    int ack_rise_cyc = -1;
    int ack_fall_cyc = -1;

    always @(negedge clk) begin
        if (rst) begin
            rx_st = 0;
            ack_i = 1'b0;
            ack_fall_cyc = -1;
        end else begin
            case (rx_st)
                0: if (req_o && !rx_hold) begin
                    rx_cnt = rx_delay;
                    rx_st = 1;
                end
                1: if (!rx_hold) begin
                    if (rx_cnt <= 1) begin
                        ack_i = 1'b1;
                        ack_rise_cyc = cyc;
                        rx_st = 2;
                    end else begin
                        rx_cnt--;
                    end
                end
                default: if (!req_o) begin
                    check(cyc - ack_rise_cyc >= SYNC + 1, "ack_rise_to_req_fall",
                          cyc - ack_rise_cyc, SYNC + 1);
                    ack_i = 1'b0;
                    ack_fall_cyc = cyc;
                    rx_st = 0;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard at each launch, then requires the data to hold.
    logic [DW-1:0] last_launch = '0;
    bit            launched_valid = 1'b0;
    logic          req_prev = 1'b0;

    always @(negedge clk) begin
        logic [DW-1:0] exp;
        if (rst) begin
            req_prev = 1'b0;
            launched_valid = 1'b0;
        end else begin
            if (req_o && !req_prev) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_launch", req_data_o, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check(req_data_o == exp, "launch_data", req_data_o, exp);
                    last_launch = exp;
                    launched_valid = 1'b1;
                end
                if (ack_fall_cyc >= 0) begin
                    check(cyc - ack_fall_cyc >= SYNC + 2, "ack_fall_to_req_rise",
                          cyc - ack_fall_cyc, SYNC + 2);
                end
            end else if (launched_valid) begin
                check(req_data_o == last_launch, "data_hold", req_data_o, last_launch);
            end
            req_prev = req_o;
        end
    end

    task automatic push(input logic [DW-1:0] d);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i = d;
        while (!in_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (in_ready_o) begin
            exp_q.push_back(d);
            last_push_edge = cyc + 1;
        end else begin
            check(1'b0, "push_accept_timeout", 32'(in_ready_o), 32'd1);
        end
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input string name);
        int n = 0;
        while (req_o !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (req_o !== lvl) check(1'b0, name, 32'(req_o), 32'(lvl));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (idle_o !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(idle_o === 1'b1, name, 32'(idle_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_push;
        int exp_cnt[5];
        exp_cnt = '{1, 2, 2, 3, 4};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(req_o == 1'b0, "rst_req", 32'(req_o), 32'd0);
        check(in_ready_o == 1'b1, "rst_in_ready", 32'(in_ready_o), 32'd1);
        check(idle_o == 1'b1, "rst_idle", 32'(idle_o), 32'd1);
        check(count_o == 3'd0, "rst_count", 32'(count_o), 32'd0);
        check(req_data_o == '0, "rst_req_data", req_data_o, 32'd0);
`ifdef HS4_TX_TIMEOUT_EN
        check(timeout_o == 1'b0, "rst_timeout", 32'(timeout_o), 32'd0);
`endif

        // Single word: launch two edges after the push.
        rx_delay = 3;
        push(32'hDEAD_BEEF);
        t_push = last_push_edge;
        wait_req(1'b1, "single_req_timeout");
        check(cyc - t_push == 2, "push_to_req_latency", cyc - t_push, 32'd2);
        wait_idle("single_idle");
        check(req_o == 1'b0, "single_req_low", 32'(req_o), 32'd0);
        check(req_data_o == 32'hDEAD_BEEF, "single_data_kept", req_data_o, 32'hDEAD_BEEF);

        // Burst of six into a four-deep FIFO with a slow receiver.
        rx_delay = 10;
        for (int i = 0; i < 5; i++) begin
            push(32'(i + 1));
            check(count_o == 3'(exp_cnt[i]), "burst_count", 32'(count_o), exp_cnt[i]);
        end
        check(in_ready_o == 1'b0, "full_ready_low", 32'(in_ready_o), 32'd0);
        check(count_o == 3'd4, "full_count", 32'(count_o), 32'd4);
        push(32'd6);
        check(count_o == 3'd4, "sixth_after_pop_count", 32'(count_o), 32'd4);
        wait_idle("burst_idle");

        // Fast receiver back-to-back transfers.
        rx_delay = 1;
        push(32'hA5A5_0001);
        push(32'hA5A5_0002);
        push(32'hA5A5_0003);
        wait_idle("b2b_idle");

        // Reset mid-ASSERT flushes queued words and drops req asynchronously.
        rx_hold = 1'b1;
        push(32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        wait_req(1'b1, "rst_mid_req_timeout");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check(req_o == 1'b0, "rst_mid_req", 32'(req_o), 32'd0);
        check(count_o == 3'd0, "rst_mid_count", 32'(count_o), 32'd0);
        check(in_ready_o == 1'b1, "rst_mid_ready", 32'(in_ready_o), 32'd1);
        check(idle_o == 1'b1, "rst_mid_idle", 32'(idle_o), 32'd1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        rx_hold = 1'b0;
        rx_delay = 2;
        push(32'hCAFE_F00D);
        wait_req(1'b1, "post_rst_req_timeout");
        wait_idle("post_rst_idle");

`ifdef HS4_TX_TIMEOUT_EN
        begin
            int t_launch;
            int n = 0;
            check(timeout_o == 1'b0, "pre_timeout_low", 32'(timeout_o), 32'd0);
            rx_hold = 1'b1;
            push(32'h7777_0000);
            wait_req(1'b1, "tmo_req_timeout");
            t_launch = cyc;
            while (timeout_o !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check(cyc - t_launch == TMO, "timeout_latency", cyc - t_launch, TMO);
            rx_hold = 1'b0;
            wait_idle("tmo_late_ack_idle");
            check(timeout_o == 1'b1, "timeout_sticky", 32'(timeout_o), 32'd1);
            tmo_clr_i = 1'b1;
            @(negedge clk);
            tmo_clr_i = 1'b0;
            check(timeout_o == 1'b0, "timeout_cleared", 32'(timeout_o), 32'd0);
        end
`endif

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
